// File: rtl/heichips25_spi_regfile.sv
// SPI mode-0 target exposing a bank of byte-wide configuration registers plus one
// read-only status byte. All SPI pins are oversampled and edge-detected on clk.
module heichips25_spi_regfile #(
    parameter int unsigned NREGS       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spi_sclk,
    input  logic                     spi_cs_n,
    input  logic                     spi_mosi,
    output logic                     spi_miso,
    output logic                     spi_miso_oe,
    input  logic [7:0]               status_in,
    output logic [8*NREGS-1:0]       cfg_regs,
    output logic                     wr_stb,
    output logic [$clog2(NREGS)-1:0] wr_addr
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam logic [AW-1:0] StatusAddr = AW'(NREGS - 1);
    localparam logic [AW-1:0] AddrOne    = AW'(1);

    typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] flush_q, flush_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   armed_q, armed_d;

    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             shift_in_q, shift_in_d;
    logic [7:0]             shift_out_q, shift_out_d;
    logic                   rw_q, rw_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [NREGS-1:0][7:0]  regs_q, regs_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic                   wr_stb_q, wr_stb_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;

    logic          sclk_s, cs_s, mosi_s;
    logic          sclk_rise, sclk_fall, cs_fall;
    logic [7:0]    byte_in;
    logic [AW-1:0] addr_next, rd_addr;
    logic [7:0]    rd_data;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        flush_d     = {flush_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Only a falling cs_n that follows a genuinely observed high level opens a frame, so a
    // frame already in progress at reset release is ignored.
    assign armed_d     = armed_q | (flush_q[SYNC_STAGES-1] & cs_s);
    assign sclk_prev_d = sclk_s;
    assign cs_prev_d   = cs_s;
    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign cs_fall     = ~cs_s & cs_prev_q & armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            flush_q     <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            flush_q     <= flush_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            armed_q     <= armed_d;
        end
    end

    assign byte_in   = {shift_in_q, mosi_s};
    assign addr_next = addr_q + AddrOne;
    // Address of the byte that follows the one just completed.
    assign rd_addr   = (state_q == StCmd) ? byte_in[AW-1:0] : addr_next;
    assign rd_data   = (rd_addr == StatusAddr) ? status_in : regs_q[rd_addr];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        regs_d      = regs_q;
        miso_d      = miso_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;

        if (cs_s) begin
            state_d   = StIdle;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_d   = StCmd;
                        bit_cnt_d = 3'd0;
                    end
                end
                StCmd, StData: begin
                    if (sclk_rise) begin
                        shift_in_d = byte_in[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            shift_out_d = rd_data;
                            if (state_q == StCmd) begin
                                rw_d    = byte_in[7];
                                addr_d  = byte_in[AW-1:0];
                                state_d = StData;
                            end else begin
                                if (rw_q && (addr_q != StatusAddr)) begin
                                    regs_d[addr_q] = byte_in;
                                    wr_stb_d       = 1'b1;
                                    wr_addr_d      = addr_q;
                                end
                                addr_d = addr_next;
                            end
                        end
                    end else if (sclk_fall) begin
                        if ((state_q == StData) && !rw_q) begin
                            miso_d      = shift_out_q[7];
                            shift_out_d = {shift_out_q[6:0], 1'b0};
                        end else begin
                            miso_d = 1'b0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign miso_oe_d = (state_d != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            shift_in_q  <= 7'd0;
            shift_out_q <= 8'd0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            regs_q      <= '0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            regs_q      <= regs_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign cfg_regs    = regs_q;
    assign spi_miso    = miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign wr_stb      = wr_stb_q;
    assign wr_addr     = wr_addr_q;

endmodule

// File: tb/tb_heichips25_spi_regfile.sv
// Bench for heichips25_spi_regfile: table-driven single-byte frames plus hand-written
// reset, burst, read, abort and full-speed sequences, checked against a register model.
module tb_heichips25_spi_regfile;

    localparam int NREGS = 8;
    localparam int SYNC  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [7:0]  status_in = 8'hA5;
    logic [63:0] cfg_regs;
    logic        wr_stb;
    logic [2:0]  wr_addr;

    heichips25_spi_regfile #(
        .NREGS       (NREGS),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .status_in   (status_in),
        .cfg_regs    (cfg_regs),
        .wr_stb      (wr_stb),
        .wr_addr     (wr_addr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failures = 0;
    int cyc = 0;
    int last_rise_cyc = 0;
    int stb_cnt = 0;

    logic [7:0]  mregs [NREGS];
    logic [2:0]  last_wr = 3'd0;
    logic [10:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [7:0]  tx_buf [32];
    logic [7:0]  rx_buf [32];

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] exp_rx;
        int         exp_stb;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_cfg();
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < NREGS - 1; k++) v[8*k +: 8] = mregs[k];
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the top nbits of tx, MSB first; MISO is sampled at the end of each high phase.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input int half,
                            output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            tick(half);
            spi_sclk = 1'b1;
            last_rise_cyc = cyc;
            tick(half);
            rx[i] = spi_miso;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int nbytes, input int half);
        logic [7:0] rx;
        logic [7:0] e;
        logic [2:0] a;
        a = cmd[2:0];
        spi_cs_n = 1'b0;
        tick(4);
        check("miso_oe_active", spi_miso_oe, 1);
        spi_bits(cmd, 8, half, rx);
        check("cmd_miso", rx, 0);
        for (int j = 0; j < nbytes; j++) begin
            if (cmd[7]) begin
                rd_q.push_back(8'h00);
                if (a != 3'(NREGS - 1)) begin
                    wr_q.push_back({a, tx_buf[j]});
                    mregs[a] = tx_buf[j];
                    last_wr = a;
                end
            end else begin
                rd_q.push_back((a == 3'(NREGS - 1)) ? status_in : mregs[a]);
            end
            spi_bits(tx_buf[j], 8, half, rx);
            rx_buf[j] = rx;
            e = rd_q.pop_front();
            check("data_miso", rx, e);
            a = a + 3'd1;
        end
        tick(4);
        spi_cs_n = 1'b1;
        tick(8);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Write scoreboard: every strobe must match the oldest expected write and its latency.
    always @(negedge clk) begin
        if (!rst && wr_stb) begin
            stb_cnt++;
            if (wr_q.size() == 0) begin
                check("unexpected_wr_stb", wr_stb, 0);
            end else begin
                logic [10:0] ex;
                ex = wr_q.pop_front();
                check("wr_addr", wr_addr, ex[10:8]);
                check("wr_data", cfg_regs[8*ex[10:8] +: 8], ex[7:0]);
                check("stb_lag", cyc - last_rise_cyc, SYNC + 1);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        logic [7:0] rx;

        for (int k = 0; k < NREGS; k++) mregs[k] = 8'h00;
        vecs[0] = '{8'h83, 8'h5A, 8'h00, 1};
        vecs[1] = '{8'h03, 8'h00, 8'h5A, 0};
        vecs[2] = '{8'h80, 8'hFF, 8'h00, 1};
        vecs[3] = '{8'h87, 8'h12, 8'h00, 0};
        vecs[4] = '{8'h07, 8'h00, 8'hA5, 0};
        vecs[5] = '{8'h00, 8'h00, 8'hFF, 0};
        vecs[6] = '{8'hF5, 8'h3C, 8'h00, 1};
        vecs[7] = '{8'h75, 8'h00, 8'h3C, 0};
        vecs[8] = '{8'h02, 8'h00, 8'h00, 0};

        // Reset values
        tick(3);
        check("rst_cfg", cfg_regs, 0);
        check("rst_stb", wr_stb, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_miso", spi_miso, 0);
        check("rst_miso_oe", spi_miso_oe, 0);
        rst = 1'b0;
        tick(6);

        // T1: reset in the middle of a write frame; the rest of that frame is ignored
        tx_buf[0] = 8'h77;
        run_frame(8'h81, 1, 4);
        check("t1_pre_cfg", cfg_regs, model_cfg());
        spi_cs_n = 1'b0;
        tick(4);
        spi_bits(8'h81, 8, 4, rx);
        spi_bits(8'hAA, 4, 4, rx);
        rst = 1'b1;
        for (int k = 0; k < NREGS; k++) mregs[k] = 8'h00;
        last_wr = 3'd0;
        tick(3);
        rst = 1'b0;
        s0 = stb_cnt;
        spi_bits(8'h55, 8, 4, rx);
        spi_bits(8'h55, 8, 4, rx);
        tick(4);
        check("t1_cfg", cfg_regs, 0);
        check("t1_miso_oe", spi_miso_oe, 0);
        check("t1_stb", stb_cnt - s0, 0);
        spi_cs_n = 1'b1;
        tick(8);

        // Table of single-byte frames (first entry is the basic write)
        for (int i = 0; i < 9; i++) begin
            tx_buf[0] = vecs[i].data;
            s0 = stb_cnt;
            run_frame(vecs[i].cmd, 1, 4);
            check("vec_rx", rx_buf[0], vecs[i].exp_rx);
            check("vec_stb", stb_cnt - s0, vecs[i].exp_stb);
            check("vec_cfg", cfg_regs, model_cfg());
            check("vec_wr_addr", wr_addr, last_wr);
            check("vec_miso_oe_idle", spi_miso_oe, 0);
        end

        // T3: burst write across the status address and wrap to 0
        tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33;
        s0 = stb_cnt;
        run_frame(8'h86, 3, 4);
        check("t3_stb", stb_cnt - s0, 2);
        check("t3_reg6", cfg_regs[55:48], 8'h11);
        check("t3_reg7", cfg_regs[63:56], 8'h00);
        check("t3_reg0", cfg_regs[7:0], 8'h33);
        check("t3_wr_addr", wr_addr, 0);

        // T4: reads with auto-increment and status
        tx_buf[0] = 8'hC3;
        run_frame(8'h82, 1, 4);
        tx_buf[0] = 8'h00; tx_buf[1] = 8'h00;
        run_frame(8'h02, 2, 4);
        check("t4_reg2", rx_buf[0], 8'hC3);
        check("t4_reg3", rx_buf[1], 8'h5A);
        run_frame(8'h07, 1, 4);
        check("t4_status", rx_buf[0], 8'hA5);
        status_in = 8'h3E;
        run_frame(8'h07, 1, 4);
        check("t4_status2", rx_buf[0], 8'h3E);

        // T5: abort mid-byte
        s0 = stb_cnt;
        spi_cs_n = 1'b0;
        tick(4);
        spi_bits(8'h81, 8, 4, rx);
        spi_bits(8'hFF, 5, 4, rx);
        tick(4);
        spi_cs_n = 1'b1;
        tick(8);
        check("t5_stb", stb_cnt - s0, 0);
        check("t5_reg1", cfg_regs[15:8], mregs[1]);
        check("t5_miso_oe", spi_miso_oe, 0);

        // cs_n rise coinciding with the 8th data rise: cs_n wins
        spi_cs_n = 1'b0;
        tick(4);
        spi_bits(8'h84, 8, 4, rx);
        spi_bits(8'hE7, 7, 4, rx);
        spi_mosi = 1'b1;
        tick(4);
        spi_sclk = 1'b1;
        spi_cs_n = 1'b1;
        tick(8);
        spi_sclk = 1'b0;
        tick(8);
        check("race_stb", stb_cnt - s0, 0);
        check("race_cfg", cfg_regs, model_cfg());

        // sclk toggling with cs_n high is ignored
        spi_bits(8'hFF, 8, 4, rx);
        spi_bits(8'hFF, 8, 4, rx);
        tick(4);
        check("idle_sclk_stb", stb_cnt - s0, 0);
        check("idle_sclk_miso", spi_miso, 0);

        // T6: 16-byte bursts at sclk = clk/4
        for (int j = 0; j < 16; j++) tx_buf[j] = 8'(j * 37 + 5);
        s0 = stb_cnt;
        run_frame(8'h80, 16, 2);
        check("t6_stb", stb_cnt - s0, 14);
        check("t6_cfg", cfg_regs, model_cfg());
        for (int j = 0; j < 16; j++) tx_buf[j] = 8'h00;
        run_frame(8'h00, 16, 2);
        check("t6_rb_first", rx_buf[8], tx_buf[0] ^ 8'(8 * 37 + 5));

        tick(10);
        check("wr_q_empty", wr_q.size(), 0);
        check("rd_q_empty", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
